// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared types, constants and config check for the dual-port on-chip RAM
package onchip_mem_pkg;

    typedef logic [1:0] clr_state_t;
    localparam clr_state_t CLR_IDLE  = 2'd0;
    localparam clr_state_t CLR_CLEAR = 2'd1;
    localparam clr_state_t CLR_DONE  = 2'd2;

    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

    function automatic bit mem_cfg_ok(input int data_w, input int addr_w, input int depth, input int rd_lat);
        return (data_w > 0) && (data_w % 8 == 0) && (depth > 0) && (addr_w > 0) && (addr_w < 31) &&
               ((1 << addr_w) >= depth) && ((rd_lat == RD_LAT_1) || (rd_lat == RD_LAT_2));
    endfunction

endpackage

// File: rtl/onchip_mem_rd_pipe.sv
// rtl/onchip_mem_rd_pipe.sv - per-port read-return pipeline (valid/data latency, flush on reset)
module onchip_mem_rd_pipe
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              rd_issue,
    input  logic [DATA_W-1:0] rd_word,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid
);

    localparam bit TWO_STAGE = (READ_LATENCY == RD_LAT_2);

    logic v1_q, v1_d;

    // A stage that drives readdatavalid never holds across ~ce, so each read pulses once.
    always_comb begin
        v1_d = ce ? rd_issue : (TWO_STAGE ? v1_q : 1'b0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
        end
    end

    if (TWO_STAGE) begin : g_lat2
        logic              v2_q, v2_d;
        logic [DATA_W-1:0] d2_q, d2_d;

        always_comb begin
            v2_d = ce & v1_q;
            d2_d = (ce && v1_q) ? rd_word : d2_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v2_d;
                d2_q <= d2_d;
            end
        end

        assign readdata      = d2_q;
        assign readdatavalid = v2_q;
    end else begin : g_lat1
        assign readdata      = rd_word;
        assign readdatavalid = v1_q;
    end

endmodule

// File: rtl/nios2system_onchip_memory_dp.sv
// rtl/nios2system_onchip_memory_dp.sv - true-dual-port on-chip RAM, Avalon-MM slaves s1 (A) and s2 (B)
// Optional post-reset zero fill enabled by defining ONCHIP_MEM_INIT_CLEAR_EN.
module nios2system_onchip_memory_dp
    import onchip_mem_pkg::*;
#(
    parameter int  DATA_W       = 32,
    parameter int  DEPTH        = 22500,
    parameter int  ADDR_W       = 15,
    parameter int  READ_LATENCY = 1,
    localparam int BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              reset_req,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [BE_W-1:0]   a_byteenable,
    input  logic              a_chipselect,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_writedata,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,
    output logic              a_waitrequest,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic              b_chipselect,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_writedata,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,
    output logic              b_waitrequest
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    if (!mem_cfg_ok(DATA_W, ADDR_W, DEPTH, READ_LATENCY)) begin : g_bad_cfg
        $error("nios2system_onchip_memory_dp: illegal DATA_W/ADDR_W/DEPTH/READ_LATENCY");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic             ce;
    logic             clr_busy;
    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;

    assign ce = clken & ~reset_req;

`ifdef ONCHIP_MEM_INIT_CLEAR_EN
    clr_state_t       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        if (state_q == CLR_CLEAR && ce) begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = CLR_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLR_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clr_busy = (state_q == CLR_CLEAR);
    assign clr_idx  = cnt_q;
`else
    assign clr_busy = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_idx  = '0;
`endif

    assign a_waitrequest = ~ce | clr_busy;
    assign b_waitrequest = ~ce | clr_busy;

    logic             a_acc, b_acc, a_in_rng, b_in_rng;
    logic             a_we, b_we, a_re, b_re;
    logic [IDX_W-1:0] a_idx, b_idx;

    // A write on the same port as a read takes precedence; the read is simply not issued.
    always_comb begin
        a_acc    = a_chipselect & (a_read | a_write) & ~a_waitrequest;
        b_acc    = b_chipselect & (b_read | b_write) & ~b_waitrequest;
        a_in_rng = {1'b0, a_address} < DEPTH_V;
        b_in_rng = {1'b0, b_address} < DEPTH_V;
        a_we     = a_acc & a_write & ~freeze & a_in_rng;
        b_we     = b_acc & b_write & ~freeze & b_in_rng;
        a_re     = a_acc & a_read & ~a_write;
        b_re     = b_acc & b_read & ~b_write;
        a_idx    = a_address[IDX_W-1:0];
        b_idx    = b_address[IDX_W-1:0];
    end

    // Port A lanes are written last so they win a same-address, same-lane collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end
        for (int i = 0; i < BE_W; i++) begin
            if (b_we && b_byteenable[i]) begin
                mem[b_idx][i*8 +: 8] <= b_writedata[i*8 +: 8];
            end
            if (a_we && a_byteenable[i]) begin
                mem[a_idx][i*8 +: 8] <= a_writedata[i*8 +: 8];
            end
        end
    end

    logic [DATA_W-1:0] a_raw_q, a_raw_d, b_raw_q, b_raw_d;

    always_comb begin
        a_raw_d = a_raw_q;
        b_raw_d = b_raw_q;
        if (a_re) begin
            a_raw_d = a_in_rng ? mem[a_idx] : '0;
        end
        if (b_re) begin
            b_raw_d = b_in_rng ? mem[b_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_raw_q <= '0;
            b_raw_q <= '0;
        end else begin
            a_raw_q <= a_raw_d;
            b_raw_q <= b_raw_d;
        end
    end

    onchip_mem_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_rd_pipe_a (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .rd_issue     (a_re),
        .rd_word      (a_raw_q),
        .readdata     (a_readdata),
        .readdatavalid(a_readdatavalid)
    );

    onchip_mem_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_rd_pipe_b (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .rd_issue     (b_re),
        .rd_word      (b_raw_q),
        .readdata     (b_readdata),
        .readdatavalid(b_readdatavalid)
    );

endmodule
